// File: rtl/jp_pkg.sv
// Shared definitions for the joypad poller: FSM encoding, CPU register map, pad bit indices.
package jp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StBitLo,
        StBitHi,
        StCommit
    } jp_state_e;

    localparam logic [15:0] AddrPort1 = 16'h4016;
    localparam logic [15:0] AddrPort2 = 16'h4017;

    localparam int unsigned BtnA      = 0;
    localparam int unsigned BtnB      = 1;
    localparam int unsigned BtnSelect = 2;
    localparam int unsigned BtnStart  = 3;
    localparam int unsigned BtnUp     = 4;
    localparam int unsigned BtnDown   = 5;
    localparam int unsigned BtnLeft   = 6;
    localparam int unsigned BtnRight  = 7;

endpackage

// File: rtl/jp_port.sv
// CPU-side read shifter for one pad: reloads while strobed, otherwise shifts right on read
// and fills with 1 so reads past the eighth return 1.
module jp_port (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strobe_i,
    input  logic [7:0] load_i,
    input  logic       shift_i,
    output logic       bit_o
);

    logic [7:0] shift_q, shift_d;

    always_comb begin
        shift_d = shift_q;
        if (strobe_i) begin
            shift_d = load_i;
        end else if (shift_i) begin
            shift_d = {1'b1, shift_q[7:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= 8'hFF;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign bit_o = shift_q[0];

endmodule

// File: rtl/jp_poller.sv
// Periodically polls two serial joypads into committed state registers and exposes them
// to the CPU through the 4016/4017 strobe/shift register interface.
module jp_poller
    import jp_pkg::*;
#(
    parameter int unsigned POLL_DIV = 1666667,
    parameter int unsigned HALF_BIT = 300
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        jp_data1_in,
    input  logic        jp_data2_in,
    output logic        jp_clk_out,
    output logic        jp_latch_out,
    input  logic        cpu_ce_in,
    input  logic [15:0] a_in,
    input  logic        r_nw_in,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic [7:0]  pad1_state_out,
    output logic [7:0]  pad2_state_out,
    output logic        poll_done_out
);

    localparam int unsigned CntW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TmrW = (HALF_BIT > 0) ? $clog2(2 * HALF_BIT) + 1 : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(POLL_DIV - 1);
    localparam logic [TmrW-1:0] LatchEnd = TmrW'(2 * HALF_BIT - 1);
    localparam logic [TmrW-1:0] HalfEnd  = TmrW'(HALF_BIT - 1);

    logic [CntW-1:0] cnt_q;
    logic            poll_req;

    always_ff @(posedge clk_in) begin
        if (rst_in || (cnt_q == CntLast)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign poll_req = (cnt_q == CntLast);

    jp_state_e       state_q;
    logic [TmrW-1:0] tmr_q;
    logic [2:0]      idx_q;
    logic [7:0]      shadow1_q, shadow2_q;
    logic [7:0]      pad1_q, pad2_q;
    logic            clk_q, latch_q, done_q;

    // Poll requests seen outside StIdle are simply ignored.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            idx_q     <= 3'(BtnA);
            shadow1_q <= 8'h00;
            shadow2_q <= 8'h00;
            pad1_q    <= 8'h00;
            pad2_q    <= 8'h00;
            clk_q     <= 1'b0;
            latch_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (poll_req) begin
                        state_q <= StLatch;
                        latch_q <= 1'b1;
                        tmr_q   <= '0;
                        idx_q   <= 3'(BtnA);
                    end
                end
                StLatch: begin
                    if (tmr_q == LatchEnd) begin
                        state_q <= StBitLo;
                        latch_q <= 1'b0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StBitLo: begin
                    if (tmr_q == HalfEnd) begin
                        shadow1_q[idx_q] <= ~jp_data1_in;
                        shadow2_q[idx_q] <= ~jp_data2_in;
                        state_q          <= StBitHi;
                        clk_q            <= 1'b1;
                        tmr_q            <= '0;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StBitHi: begin
                    if (tmr_q == HalfEnd) begin
                        clk_q   <= 1'b0;
                        tmr_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        state_q <= (idx_q == 3'(BtnRight)) ? StCommit : StBitLo;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StCommit: begin
                    pad1_q  <= shadow1_q;
                    pad2_q  <= shadow2_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic strobe_q;
    logic sel1, sel2, bit1, bit2;
    logic unused_d;

    assign unused_d = ^d_in[7:1];
    assign sel1     = cpu_ce_in && r_nw_in && (a_in == AddrPort1);
    assign sel2     = cpu_ce_in && r_nw_in && (a_in == AddrPort2);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            strobe_q <= 1'b0;
        end else if (cpu_ce_in && !r_nw_in && (a_in == AddrPort1)) begin
            strobe_q <= d_in[0];
        end
    end

    jp_port u_port1 (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .strobe_i (strobe_q),
        .load_i   (pad1_q),
        .shift_i  (sel1),
        .bit_o    (bit1)
    );

    jp_port u_port2 (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .strobe_i (strobe_q),
        .load_i   (pad2_q),
        .shift_i  (sel2),
        .bit_o    (bit2)
    );

    always_comb begin
        d_out = 8'h00;
        if (sel1) begin
            d_out = {7'b0, bit1};
        end else if (sel2) begin
            d_out = {7'b0, bit2};
        end
    end

    assign jp_clk_out     = clk_q;
    assign jp_latch_out   = latch_q;
    assign poll_done_out  = done_q;
    assign pad1_state_out = pad1_q;
    assign pad2_state_out = pad2_q;

endmodule

// File: tb/tb_jp_poller.sv
// Scoreboard bench for jp_poller: serial pad models feed the poller, expected reads and
// commits are queued by the stimulus and checked by a negedge monitor.
module tb_jp_poller;

    localparam int unsigned PollDiv = 100;
    localparam int unsigned HalfBit = 2;
    localparam logic [15:0] AP1     = 16'h4016;
    localparam logic [15:0] AP2     = 16'h4017;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        jp_data1_in, jp_data2_in;
    logic        jp_clk_out, jp_latch_out;
    logic        cpu_ce_in = 1'b0;
    logic [15:0] a_in      = 16'h0000;
    logic        r_nw_in   = 1'b0;
    logic [7:0]  d_in      = 8'h00;
    logic [7:0]  d_out;
    logic [7:0]  pad1_state_out, pad2_state_out;
    logic        poll_done_out;

    jp_poller #(
        .POLL_DIV (PollDiv),
        .HALF_BIT (HalfBit)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .jp_data1_in    (jp_data1_in),
        .jp_data2_in    (jp_data2_in),
        .jp_clk_out     (jp_clk_out),
        .jp_latch_out   (jp_latch_out),
        .cpu_ce_in      (cpu_ce_in),
        .a_in           (a_in),
        .r_nw_in        (r_nw_in),
        .d_in           (d_in),
        .d_out          (d_out),
        .pad1_state_out (pad1_state_out),
        .pad2_state_out (pad2_state_out),
        .poll_done_out  (poll_done_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int latch_cycles = 0;
    int clk_rises = 0;
    logic clk_prev = 1'b0;
    logic [7:0]  rd_q[$];
    logic [15:0] commit_q[$];
    logic [7:0]  rd_exp;
    logic [15:0] commit_exp;

    // Pad model: buttons held active-high here, driven active-low onto the pad data line.
    logic [7:0] pad1_bits = 8'h00, pad2_bits = 8'h00;
    logic [7:0] p1 = 8'h00, p2 = 8'h00;
    logic       pclk_q = 1'b0;

    always @(posedge clk_in) begin
        if (jp_latch_out) begin
            p1 <= pad1_bits;
            p2 <= pad2_bits;
        end else if (jp_clk_out && !pclk_q) begin
            p1 <= {1'b0, p1[7:1]};
            p2 <= {1'b0, p2[7:1]};
        end
        pclk_q <= jp_clk_out;
    end

    assign jp_data1_in = ~p1[0];
    assign jp_data2_in = ~p2[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each latch pulse is the stimulus that determines the next commit.
    always @(posedge jp_latch_out) commit_q.push_back({pad2_bits, pad1_bits});

    always @(negedge clk_in) begin
        if (jp_latch_out) latch_cycles++;
        if (jp_clk_out && !clk_prev) clk_rises++;
        clk_prev = jp_clk_out;
        if (cpu_ce_in && r_nw_in) begin
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0h expected none", d_out);
            end else begin
                rd_exp = rd_q.pop_front();
                check("rd_data", {24'h0, d_out}, {24'h0, rd_exp});
            end
        end
        if (poll_done_out) begin
            if (commit_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got %0h expected none",
                         {pad2_state_out, pad1_state_out});
            end else begin
                commit_exp = commit_q.pop_front();
                check("commit_pads", {16'h0, pad2_state_out, pad1_state_out}, {16'h0, commit_exp});
            end
        end
    end

    task automatic cpu_rd(input logic [15:0] addr, input logic [7:0] exp);
        rd_q.push_back(exp);
        cpu_ce_in = 1'b1;
        r_nw_in   = 1'b1;
        a_in      = addr;
        @(posedge clk_in);
        #1;
        cpu_ce_in = 1'b0;
        r_nw_in   = 1'b0;
        a_in      = 16'h0000;
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
        cpu_ce_in = 1'b1;
        r_nw_in   = 1'b0;
        a_in      = addr;
        d_in      = data;
        @(posedge clk_in);
        #1;
        cpu_ce_in = 1'b0;
        a_in      = 16'h0000;
        d_in      = 8'h00;
    endtask

    task automatic wait_latch(output int n);
        logic prev;
        prev = jp_latch_out;
        n = 0;
        while (n < 400) begin
            @(posedge clk_in);
            #1;
            n++;
            if (jp_latch_out && !prev) return;
            prev = jp_latch_out;
        end
        errors++;
        $display("FAIL latch_timeout: got no latch within %0d cycles", n);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_in);
            #1;
            if (poll_done_out) return;
        end
        errors++;
        $display("FAIL done_timeout: got no poll_done_out within 400 cycles");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk"}, {31'h0, jp_clk_out}, 32'h0);
        check({tag, "_latch"}, {31'h0, jp_latch_out}, 32'h0);
        check({tag, "_done"}, {31'h0, poll_done_out}, 32'h0);
        check({tag, "_pad1"}, {24'h0, pad1_state_out}, 32'h0);
        check({tag, "_pad2"}, {24'h0, pad2_state_out}, 32'h0);
    endtask

    logic [7:0] exp_reads [10] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00,
                                   8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
    int n;
    int lc0, cr0;

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("rst0");
        cpu_rd(AP1, 8'h01);

        // First poll: pad1 A5, pad2 idle.
        pad1_bits = 8'hA5;
        pad2_bits = 8'h00;
        rst_in    = 1'b0;
        wait_latch(n);
        check("first_poll_delay", n, PollDiv);
        lc0 = latch_cycles;
        cr0 = clk_rises;
        wait_done();
        @(negedge clk_in);
        #1;
        check("latch_cycles", latch_cycles - lc0, 2 * HalfBit);
        check("clk_pulses", clk_rises - cr0, 8);

        // Strobe 1 then 0, then ten serial reads of pad1.
        cpu_wr(AP1, 8'h01);
        cpu_wr(AP1, 8'h00);
        for (int i = 0; i < 10; i++) cpu_rd(AP1, exp_reads[i]);

        // Strobe held high: repeated reads of pad2 never advance.
        pad2_bits = 8'h01;
        wait_latch(n);
        wait_done();
        cpu_wr(AP1, 8'h01);
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 3; i++) cpu_rd(AP2, 8'h01);
        cpu_rd(AP1, 8'h01);

        // Unselected accesses return 0 and leave the shifters untouched.
        cpu_wr(AP1, 8'h00);
        cpu_rd(16'h4018, 8'h00);
        r_nw_in = 1'b1;
        a_in    = AP1;
        #2;
        check("ce_low_dout", {24'h0, d_out}, 32'h0);
        @(posedge clk_in);
        #1;
        r_nw_in = 1'b0;
        a_in    = 16'h0000;
        cpu_rd(AP1, 8'h01);
        cpu_rd(AP1, 8'h00);
        cpu_rd(AP2, 8'h01);
        cpu_rd(AP2, 8'h00);

        // Read coincident with the commit returns the old bit; the next read sees the new one.
        pad1_bits = 8'h5A;
        cpu_wr(AP1, 8'h01);
        wait_latch(n);
        repeat (37) @(posedge clk_in);
        #1;
        check("done_align", {31'h0, poll_done_out}, 32'h1);
        cpu_rd(AP1, 8'h01);
        cpu_rd(AP1, 8'h00);

        // Reset in the high half of bit 4.
        pad1_bits = 8'hA5;
        pad2_bits = 8'h00;
        wait_latch(n);
        repeat (22) @(posedge clk_in);
        #1;
        check("bit4_hi_clk", {31'h0, jp_clk_out}, 32'h1);
        rst_in = 1'b1;
        commit_q.delete();
        @(posedge clk_in);
        #1;
        check_reset_outputs("rst_mid");
        cpu_rd(AP1, 8'h01);
        rst_in = 1'b0;
        wait_latch(n);
        check("poll_after_reset", n, PollDiv);
        wait_done();
        @(negedge clk_in);
        #1;
        check("rd_queue_drained", rd_q.size(), 0);
        check("commit_queue_drained", commit_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
